// File: rtl/regbank_write_sched_if.sv
// Write-scheduler interface: requester A/B handshakes, the clear control and
// the register bank write port.
interface regbank_write_sched_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              clr_start;
  logic              busy;
  logic              clr_done;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic              grant_b;

  // Requesters / controller side
  modport master (
    output a_valid, a_addr, a_data,
    output b_valid, b_addr, b_data,
    output clr_start,
    input  a_ready, b_ready, busy, clr_done,
    input  we3, wa3, wd3, grant_b
  );

  // Scheduler side
  modport slave (
    input  a_valid, a_addr, a_data,
    input  b_valid, b_addr, b_data,
    input  clr_start,
    output a_ready, b_ready, busy, clr_done,
    output we3, wa3, wd3, grant_b
  );
endinterface

// File: rtl/regbank_write_sched.sv
// Round-robin scheduler for the register bank's single write port, shared by
// requesters A and B, plus a clear sequence that zeroes X1..X(2**ADDR_W-1)
// through the same port.
module regbank_write_sched #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  regbank_write_sched_if.slave   bus
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_REG = '1;

  state_t            state;
  logic              ptr;   // 0: A has priority, 1: B has priority
  logic [ADDR_W-1:0] cnt;
  logic              can_accept;

  // Ready is decided combinationally; a pending clear start blocks both sides
  always_comb begin
    can_accept  = (state == IDLE) && !bus.clr_start;
    bus.a_ready = can_accept && bus.a_valid && (!bus.b_valid || !ptr);
    bus.b_ready = can_accept && bus.b_valid && (!bus.a_valid ||  ptr);
  end

  // FSM with registered write-port and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      cnt          <= '0;
      bus.busy     <= 1'b0;
      bus.clr_done <= 1'b0;
      bus.we3      <= 1'b0;
      bus.wa3      <= '0;
      bus.wd3      <= '0;
      bus.grant_b  <= 1'b0;
    end else begin
      bus.clr_done <= 1'b0;
      bus.we3      <= 1'b0;
      bus.grant_b  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clr_start) begin
            // First clear write (X1) is issued on the same edge the clear starts
            state    <= CLEAR;
            bus.busy <= 1'b1;
            cnt      <= ADDR_W'(1);
            bus.we3  <= 1'b1;
            bus.wa3  <= ADDR_W'(1);
            bus.wd3  <= '0;
          end else if (bus.a_ready) begin
            bus.we3 <= 1'b1;
            bus.wa3 <= bus.a_addr;
            bus.wd3 <= bus.a_data;
            ptr     <= 1'b1;
          end else if (bus.b_ready) begin
            bus.we3     <= 1'b1;
            bus.wa3     <= bus.b_addr;
            bus.wd3     <= bus.b_data;
            bus.grant_b <= 1'b1;
            ptr         <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt == LAST_REG) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.clr_done <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt     <= cnt + 1'b1;
            bus.we3 <= 1'b1;
            bus.wa3 <= cnt + 1'b1;
            bus.wd3 <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regbank_write_sched.sv
// Bench for regbank_write_sched: directed scenarios followed by a random phase,
// checked cycle by cycle against a transaction-level reference model, with a
// simple 8x8 bank attached to the write port.
module tb_regbank_write_sched;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NREG = 2 ** AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regbank_write_sched_if #(.DATA_W(DW), .ADDR_W(AW)) bif ();
  regbank_write_sched #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  // Register bank hanging off the write port; X0 is hard-wired to zero
  logic [DW-1:0] dut_bank [NREG] = '{default: 8'h00};
  always @(posedge clk)
    if (bif.we3 && bif.wa3 != 0) dut_bank[bif.wa3] <= bif.wd3;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: expected registered outputs for the current cycle
  bit            m_busy, m_done, m_we, m_gb, m_ptr;
  int            m_rem;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] exp_bank [NREG] = '{default: 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_we = 0; m_gb = 0; m_ptr = 0; m_rem = 0;
    m_wa = '0; m_wd = '0;
  endtask

  task automatic idle_inputs();
    bif.a_valid = 0; bif.a_addr = '0; bif.a_data = '0;
    bif.b_valid = 0; bif.b_addr = '0; bif.b_data = '0;
    bif.clr_start = 0;
  endtask

  // One clock cycle: check outputs at the falling edge, then advance the model
  // to what the next rising edge should produce.
  task automatic cyc(output bit a_acc, output bit b_acc);
    bit ar, br, idle;
    @(negedge clk);
    idle = !m_busy;
    ar = idle && !bif.clr_start && bif.a_valid && (!bif.b_valid || !m_ptr);
    br = idle && !bif.clr_start && bif.b_valid && (!bif.a_valid || m_ptr);
    chk("a_ready", bif.a_ready, ar);
    chk("b_ready", bif.b_ready, br);
    chk("busy", bif.busy, m_busy);
    chk("clr_done", bif.clr_done, m_done);
    chk("we3", bif.we3, m_we);
    if (m_we) begin
      chk("wa3", bif.wa3, m_wa);
      chk("wd3", bif.wd3, m_wd);
      chk("grant_b", bif.grant_b, m_gb);
    end
    if (m_we && m_wa != 0) exp_bank[m_wa] = m_wd;
    m_done = 0; m_we = 0; m_gb = 0;
    if (m_busy) begin
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1;
      end else begin
        m_we = 1; m_wa = AW'(NREG - m_rem); m_wd = '0; m_rem--;
      end
    end else if (bif.clr_start) begin
      m_busy = 1; m_we = 1; m_wa = AW'(1); m_wd = '0; m_rem = NREG - 2;
    end else if (ar) begin
      m_we = 1; m_wa = bif.a_addr; m_wd = bif.a_data; m_ptr = 1;
    end else if (br) begin
      m_we = 1; m_wa = bif.b_addr; m_wd = bif.b_data; m_gb = 1; m_ptr = 0;
    end
    a_acc = ar;
    b_acc = br;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    #1;
    model_reset();
    chk("rst_we3", bif.we3, 0);
    chk("rst_wa3", bif.wa3, 0);
    chk("rst_wd3", bif.wd3, 0);
    chk("rst_busy", bif.busy, 0);
    chk("rst_clr_done", bif.clr_done, 0);
    chk("rst_grant_b", bif.grant_b, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit aa, bb, got;
    got = 0;
    bif.a_valid = 1; bif.a_addr = addr; bif.a_data = data;
    for (int k = 0; k < 30 && !got; k++) begin
      cyc(aa, bb);
      got = aa;
    end
    bif.a_valid = 0;
    if (!got) begin
      compared++; mismatched++;
      $display("FAIL a_accept_timeout observed=0 expected=1");
    end
  endtask

  task automatic load_all();
    bit aa, bb;
    for (int unsigned i = 1; i < NREG; i++) write_a(AW'(i), DW'(i * 8'h11));
    cyc(aa, bb);
  endtask

  initial begin
    bit aa, bb, pend_a, pend_b, first_b, got_a, got_b;
    idle_inputs();
    rst = 0;
    model_reset();
    #2;
    do_reset();

    // Single A write to X1
    write_a(AW'(1), 8'hAA);
    cyc(aa, bb);
    cyc(aa, bb);
    chk("x1_after_a", dut_bank[1], 8'hAA);

    // Both requesters together from a fresh pointer: A first, then B
    do_reset();
    bif.a_valid = 1; bif.a_addr = AW'(2); bif.a_data = 8'hBB;
    bif.b_valid = 1; bif.b_addr = AW'(3); bif.b_data = 8'hCC;
    got_a = 0; got_b = 0; first_b = 0;
    for (int k = 0; k < 10 && !(got_a && got_b); k++) begin
      cyc(aa, bb);
      if (bb && !got_a) first_b = 1;
      if (aa) begin got_a = 1; bif.a_valid = 0; end
      if (bb) begin got_b = 1; bif.b_valid = 0; end
    end
    chk("rr_both_granted", {got_a, got_b}, 2'b11);
    chk("rr_a_first", first_b, 0);
    bif.a_valid = 0; bif.b_valid = 0;
    cyc(aa, bb);
    cyc(aa, bb);
    chk("x2_bb", dut_bank[2], 8'hBB);
    chk("x3_cc", dut_bank[3], 8'hCC);

    // Full clear after loading 11..77
    load_all();
    bif.clr_start = 1;
    cyc(aa, bb);
    bif.clr_start = 0;
    repeat (10) cyc(aa, bb);
    for (int unsigned i = 0; i < NREG; i++)
      chk($sformatf("clear_x%0d", i), dut_bank[i], 8'h00);

    // Clear start races a pending A write; A lands after the clear
    bif.clr_start = 1;
    bif.a_valid = 1; bif.a_addr = AW'(4); bif.a_data = 8'hDD;
    cyc(aa, bb);
    chk("race_a_held", aa, 0);
    bif.clr_start = 0;
    got_a = 0;
    for (int k = 0; k < 20 && !got_a; k++) begin
      cyc(aa, bb);
      got_a = aa;
    end
    bif.a_valid = 0;
    chk("race_a_accepted", got_a, 1);
    cyc(aa, bb);
    cyc(aa, bb);
    chk("race_x4_dd", dut_bank[4], 8'hDD);

    // Reset three writes into a clear
    load_all();
    bif.clr_start = 1;
    cyc(aa, bb);
    bif.clr_start = 0;
    repeat (3) cyc(aa, bb);
    do_reset();
    cyc(aa, bb);
    for (int unsigned i = 1; i < NREG; i++)
      chk($sformatf("abort_x%0d", i), dut_bank[i], (i <= 3) ? 8'h00 : DW'(i * 8'h11));

    // Address 0 is forwarded; the bank keeps X0 at zero
    write_a(AW'(0), 8'hFF);
    cyc(aa, bb);
    chk("x0_zero", dut_bank[0], 8'h00);

    // Random traffic
    pend_a = 0; pend_b = 0;
    for (int n = 0; n < 400; n++) begin
      if (!pend_a) begin
        bif.a_valid = 1'($urandom_range(0, 1));
        bif.a_addr  = AW'($urandom);
        bif.a_data  = DW'($urandom);
      end
      if (!pend_b) begin
        bif.b_valid = 1'($urandom_range(0, 1));
        bif.b_addr  = AW'($urandom);
        bif.b_data  = DW'($urandom);
      end
      bif.clr_start = ($urandom_range(0, 19) == 0);
      cyc(aa, bb);
      pend_a = bif.a_valid && !aa;
      pend_b = bif.b_valid && !bb;
    end
    idle_inputs();
    repeat (10) cyc(aa, bb);
    for (int unsigned i = 0; i < NREG; i++)
      chk($sformatf("final_x%0d", i), dut_bank[i], exp_bank[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regbank_write_sched.md
Name: regbank_write_sched

Overview:
- Write-port scheduler for the 8-entry x 8-bit register bank.
- Shares the bank's single write port (we3/wa3/wd3) between two requesters, A and B, using valid/ready handshakes and round-robin arbitration.
- Also runs a clear sequence on demand: zeroes X1..X7 through the write port, without relying on the bank reset.
- Sits between the datapath/control masters and the register bank write inputs. Read ports are not touched.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 3, register address width; register count is 2**ADDR_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A has a write pending.
- a_ready  out  1  A's write is accepted this cycle.
- a_addr  in  ADDR_W  A's target register.
- a_data  in  DATA_W  A's write data.
- b_valid  in  1  requester B has a write pending.
- b_ready  out  1  B's write is accepted this cycle.
- b_addr  in  ADDR_W  B's target register.
- b_data  in  DATA_W  B's write data.
- clr_start  in  1  request a clear of X1..X7.
- busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.
- we3  out  1  bank write enable (registered).
- wa3  out  ADDR_W  bank write address (registered).
- wd3  out  DATA_W  bank write data (registered).
- grant_b  out  1  the current we3 write came from B (0 means A or clear).

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - we3, wa3, wd3, busy, clr_done and grant_b are all 0.
  - Round-robin pointer favours A.
  - Clear counter is 0.
- FSM states: IDLE, CLEAR.
- Handshake:
  - A transfer happens when x_valid=1 and x_ready=1 at a rising edge.
  - Requesters hold addr/data stable while valid=1 and not ready.
  - ready is combinational from valid, state, clr_start and the pointer.
- IDLE arbitration:
  - If clr_start=1: go to CLEAR; a_ready=b_ready=0 that cycle (clear wins over simultaneous requests).
  - Else if only one requester is valid: that one gets ready=1.
  - Else if both are valid: the pointer side gets ready=1, and the pointer flips to the other side after the grant.
  - A single-requester grant also sets the pointer to the other side.
- Write latency:
  - A transfer accepted at edge N drives we3=1, wa3=addr, wd3=data, grant_b=source during cycle N..N+1.
  - The bank stores the value at edge N+1.
  - With no transfer, we3 returns to 0 the next cycle.
  - Back-to-back transfers give we3=1 on consecutive cycles.
- Address 0 writes are forwarded unchanged; the bank's handling of X0 decides the outcome.
- CLEAR:
  - busy=1; a_ready=b_ready=0.
  - Counter runs 1..2**ADDR_W-1, one write per cycle with we3=1, wa3=counter, wd3=0, grant_b=0.
  - After the write to X7 is issued, the FSM returns to IDLE, pulses clr_done=1 for one cycle, and drops busy in that same cycle.
  - Duration is 7 write cycles for ADDR_W=3.
  - clr_start while busy is ignored; no re-queue.
  - A pending valid is held off and accepted on the first IDLE cycle after clr_done, unless clr_start is 1 again.
- Reset during CLEAR aborts the sequence immediately with no clr_done. Registers already cleared stay cleared; the rest are untouched.
- The pointer does not change during CLEAR.

Test Plan:
- Reset, then a_valid with a_addr=1, a_data=AA -> a_ready=1; next cycle we3=1, wa3=1, wd3=AA, grant_b=0; bank reads rd1=AA on X1.
- a_valid and b_valid held together, A writes X2=BB, B writes X3=CC -> grants alternate A,B: we3 cycles carry (2,BB) then (3,CC); grant_b=0 then 1; both banked.
- After X1..X7 are loaded with 11..77, pulse clr_start -> busy=1 for 7 cycles with wa3=1..7, wd3=00; clr_done pulses once; all reads give 00.
- clr_start in the same cycle as a_valid (addr 4, DD) -> a_ready=0 through CLEAR; DD is written to X4 only after clr_done; final rd=DD.
- Drop rst to 0 mid-CLEAR after 3 writes -> outputs 0 immediately, no clr_done, X1..X3=00, X4..X7 keep prior values (44..77).
- Write with a_valid and addr 0, data FF -> we3=1, wa3=0 forwarded; read of X0 returns 00.
